// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: state encoding,
// memory geometry and the command bytes recognised on the byte stream.
// No logic; imported by the interface, the loader and its word assembler.
package program_loader_pkg;

  localparam int IMEM_AW = 8;   // instruction memory word-address width
  localparam int DMEM_AW = 5;   // data memory byte-address width

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_GO   = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CNT,
    IWORD,
    DBYTE,
    RUN
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input plus memory write ports and CPU control of the loader.
// slave: the loader side; master: the host/stream source and memories.
// Handshake: a byte transfers when rx_valid_i && rx_ready_o at a clock edge.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int IAW = IMEM_AW,
  parameter int DAW = DMEM_AW
);
  logic [7:0]     rx_data_i;
  logic           rx_valid_i;
  logic           rx_ready_o;
  logic           imem_we_o;
  logic [IAW-1:0] imem_addr_o;
  logic [31:0]    imem_data_o;
  logic           dmem_we_o;
  logic [DAW-1:0] dmem_addr_o;
  logic [7:0]     dmem_data_o;
  logic           start_o;
  logic           busy_o;
  logic           err_o;

  modport slave (
    input  rx_data_i, rx_valid_i,
    output rx_ready_o, imem_we_o, imem_addr_o, imem_data_o,
           dmem_we_o, dmem_addr_o, dmem_data_o, start_o, busy_o, err_o
  );

  modport master (
    output rx_data_i, rx_valid_i,
    input  rx_ready_o, imem_we_o, imem_addr_o, imem_data_o,
           dmem_we_o, dmem_addr_o, dmem_data_o, start_o, busy_o, err_o
  );
endinterface

// File: rtl/program_loader_word_asm.sv
// Assembles four bytes into a little-endian 32-bit word (first byte = [7:0]).
// Latency: done pulses one cycle after the 4th byte; word_o holds until next.
// No backpressure: every byte_vld is taken. Ports: clk/rst_n, clr (sync),
// byte_vld/byte_dat in, last_byte (comb, 4th byte now), done, word_o out.
module loader_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        last_byte,
  output logic        done,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic [31:0] sr_q;
  logic [31:0] sr_next;

  // Shift in from the top so the first byte ends up in bits 7:0.
  assign sr_next   = {byte_dat, sr_q[31:8]};
  assign last_byte = byte_vld && !clr && (cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      sr_q   <= 32'd0;
      word_o <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= last_byte;
      if (clr) begin
        cnt_q <= 2'd0;
      end else if (byte_vld) begin
        sr_q  <= sr_next;
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) word_o <= sr_next;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses IMEM/DMEM/GO frames from a byte stream, writes the
// memories, then asserts start to the CPU. Write strobes fire 1 cycle after
// the accepting handshake. rx_ready_o is 1 in every state except RUN.
// Ports: clk_i, rst_i (async, active-low), bus (program_loader_if.slave).
module program_loader
  import program_loader_pkg::*;
#(
  parameter int IAW = IMEM_AW,
  parameter int DAW = DMEM_AW
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  program_loader_if.slave       bus
);

  state_t         state_q, state_d;
  logic           hs;
  logic           is_imem_q;
  logic [8:0]     cnt_q;        // remaining words/bytes, 1..256
  logic [IAW-1:0] idx_q;        // next instruction word index
  logic [DAW-1:0] daddr_q;      // next data byte address
  logic [IAW-1:0] imem_addr_q;
  logic           dmem_we_q;
  logic [DAW-1:0] dmem_addr_q;
  logic [7:0]     dmem_data_q;
  logic           start_q;
  logic           err_q;

  logic           asm_vld;
  logic           asm_last;
  logic           asm_done;
  logic [31:0]    asm_word;

  assign hs = bus.rx_valid_i && bus.rx_ready_o;

  // Keep the assembler parked at byte 0 whenever no word frame is active,
  // so a new frame always starts on a word boundary.
  assign asm_vld = hs && (state_q == IWORD);

  loader_word_asm u_asm (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .clr       (state_q != IWORD),
    .byte_vld  (asm_vld),
    .byte_dat  (bus.rx_data_i),
    .last_byte (asm_last),
    .done      (asm_done),
    .word_o    (asm_word)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (bus.rx_data_i == CMD_IMEM || bus.rx_data_i == CMD_DMEM) state_d = ADDR;
          else if (bus.rx_data_i == CMD_GO)                           state_d = RUN;
        end
      end
      ADDR:  if (hs) state_d = CNT;
      CNT:   if (hs) state_d = is_imem_q ? IWORD : DBYTE;
      IWORD: if (asm_last && cnt_q == 9'd1) state_d = IDLE;
      DBYTE: if (hs && cnt_q == 9'd1) state_d = IDLE;
      RUN:   state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      is_imem_q   <= 1'b0;
      cnt_q       <= 9'd0;
      idx_q       <= '0;
      daddr_q     <= '0;
      imem_addr_q <= '0;
      dmem_we_q   <= 1'b0;
      dmem_addr_q <= '0;
      dmem_data_q <= 8'd0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dmem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs) begin
            if (bus.rx_data_i == CMD_IMEM)      is_imem_q <= 1'b1;
            else if (bus.rx_data_i == CMD_DMEM) is_imem_q <= 1'b0;
            else if (bus.rx_data_i == CMD_GO)   start_q   <= 1'b1;
            else                                err_q     <= 1'b1;
          end
        end
        ADDR: begin
          if (hs) begin
            idx_q   <= IAW'(bus.rx_data_i);
            daddr_q <= DAW'(bus.rx_data_i);
          end
        end
        CNT: begin
          // A count byte of zero encodes a full 256-entry transfer.
          if (hs) cnt_q <= (bus.rx_data_i == 8'd0) ? 9'd256 : {1'b0, bus.rx_data_i};
        end
        IWORD: begin
          if (asm_last) begin
            imem_addr_q <= idx_q;
            idx_q       <= idx_q + 1'b1;
            cnt_q       <= cnt_q - 9'd1;
          end
        end
        DBYTE: begin
          if (hs) begin
            dmem_we_q   <= 1'b1;
            dmem_addr_q <= daddr_q;
            dmem_data_q <= bus.rx_data_i;
            daddr_q     <= daddr_q + 1'b1;
            cnt_q       <= cnt_q - 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready_o  = (state_q != RUN);
  assign bus.busy_o      = (state_q != IDLE) && (state_q != RUN);
  assign bus.imem_we_o   = asm_done;
  assign bus.imem_addr_o = imem_addr_q;
  assign bus.imem_data_o = asm_word;
  assign bus.dmem_we_o   = dmem_we_q;
  assign bus.dmem_addr_o = dmem_addr_q;
  assign bus.dmem_data_o = dmem_data_q;
  assign bus.start_o     = start_q;
  assign bus.err_o       = err_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer-side counterpart to the simulation state dump. Loads the instruction memory and data memory from a byte stream, then releases the CPU by asserting start.
- Sits beside CPU at top level: drives the Instruction_Memory word write port, the Data_Memory byte write port, and CPU start_i.
- Replaces the bench-only $readmemb/poke preload path with a synthesizable boot path.

Parameters:
- IMEM_AW, 8, instruction memory word-address width (256 words)
- DMEM_AW, 5, data memory byte-address width (32 bytes)
- CMD_IMEM, 8'h01, command byte: load instruction words
- CMD_DMEM, 8'h02, command byte: load data bytes
- CMD_GO, 8'hFF, command byte: assert start

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- rx_data_i  in  8  stream byte
- rx_valid_i  in  1  byte valid
- rx_ready_o  out  1  loader accepts byte; transfer when valid&&ready
- imem_we_o  out  1  instruction word write strobe, one cycle
- imem_addr_o  out  IMEM_AW  word index
- imem_data_o  out  32  instruction word
- dmem_we_o  out  1  data byte write strobe, one cycle
- dmem_addr_o  out  DMEM_AW  byte address
- dmem_data_o  out  8  data byte
- start_o  out  1  to CPU start_i; sticky once set
- busy_o  out  1  frame in progress (state != IDLE and != RUN)
- err_o  out  1  sticky unknown-command flag

Behaviour:
- Reset (async, rst_i=0): state IDLE; all outputs 0 except rx_ready_o=1. Registers are cleared immediately. A partially assembled word is discarded. No write strobe is issued during or after reset.
- Frame formats:
  - IMEM: CMD_IMEM, start word index A, count N, then N×4 bytes little-endian (first byte = bits 7:0).
  - DMEM: CMD_DMEM, start byte address A, count N, then N bytes.
  - N=0 means 256 for IMEM and 256 for DMEM.
  - GO: CMD_GO alone.
- States: IDLE -> ADDR -> CNT -> (IWORD | DBYTE) -> IDLE. CMD_GO from IDLE -> RUN.
- IDLE:
  - Unknown command byte: set err_o, consume the byte, stay in IDLE.
  - err_o clears only on reset.
- IWORD:
  - Byte counter 0..3 assembles a shift register.
  - On the cycle after the 4th byte handshake: imem_we_o=1 for exactly one cycle, with imem_addr_o=current index and imem_data_o=assembled word.
  - Index then increments mod 2^IMEM_AW (wraps 255->0). Remaining count decrements.
  - When count reaches 0 after that write: -> IDLE.
- DBYTE:
  - Cycle after each byte handshake: dmem_we_o=1 for one cycle, dmem_addr_o=address, dmem_data_o=byte.
  - Address wraps mod 2^DMEM_AW (31->0); later bytes overwrite earlier ones.
- Write strobe latency is fixed at 1 cycle after the accepting handshake. rx_ready_o stays 1 in IWORD/DBYTE. A back-to-back byte may be accepted in the same cycle as the strobe of the previous one.
- imem_we_o and dmem_we_o are never high together.
- rx_valid_i low mid-frame: the loader waits indefinitely. No timeout.
- RUN:
  - start_o=1 from the cycle after the GO handshake until reset.
  - rx_ready_o=0, busy_o=0. Further bytes are ignored and not consumed.
- Address/data outputs hold their last value when the strobe is low.

Decomposition:
- Package program_loader_pkg holds the state enum (IDLE, ADDR, CNT, IWORD, DBYTE, RUN) and the CMD_* constants.
- One natural sub-module: loader_word_asm, the 4-byte little-endian assembler with a byte counter, a done pulse, and a synchronous clear on frame end.

Test Plan:
- Reset, then stream 01 00 01 20 00 08 8C -> one imem_we_o pulse: addr 0, data 32'h8C080020. busy_o returns 0 afterwards.
- Stream 02 00 01 05, then FF -> dmem_we_o: addr 0, data 8'h05. start_o=1 the cycle after the FF handshake; rx_ready_o=0 thereafter.
- Stream 02 1F 02 AA BB -> writes addr 31=AA then addr 0=BB (wrap). IMEM A=FF N=2 writes indices 255 then 0.
- Stream byte 7E in IDLE -> err_o=1 and stays set. A following valid IMEM frame still loads correctly.
- Hold rx_valid_i=0 for 10 cycles after the 2nd data byte of an IMEM word -> no strobe; word completes correctly on resume.
- Assert rst_i=0 after 3 bytes of an IMEM word -> no imem_we_o; all outputs are 0 and rx_ready_o=1 during reset. After release, a new frame loads correctly.
